mtm_alu_deserializer: RTL and testbench
=======================================

MTM_ALU_DESERIALIZER -- requirements
Module: mtm_alu_deserializer

Interface
REQ-001 Ports, one per line (name, direction, width, meaning); clocking/reset fixed: one clock, reset asynchronous active-low.
- clk  in  1  sole clock; all sequential logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sin  in  1  serial input; idle high; one bit sampled per clk.
- out_valid  out  1  one-cycle pulse: packet decoded; out_* valid this cycle.
- out_a  out  32  operand A.
- out_b  out  32  operand B.
- out_op  out  3  opcode from the CTL frame.
- out_err  out  3  {err_data, err_crc, err_op}, valid with out_valid.
REQ-002 No parameters.

Function
REQ-003 Frame format: 11 bits, MSB first: start=0, type (0 DATA, 1 CTL), 8 payload bits, stop=1.
REQ-004 Packet format: 8 DATA frames (B[31:24], B[23:16], B[15:8], B[7:0], A[31:24] … A[7:0]), then 1 CTL frame with payload {0, OP[2:0], CRC[3:0]}.
REQ-005 Frame FSM states:
- IDLE: sin=0 -> TYPE.
- TYPE: latch type -> DATA.
- DATA: 8 cycles, shift payload MSB first -> STOP.
- STOP: evaluate stop bit -> IDLE.
REQ-006 IDLE accepts a new start bit in the cycle immediately after STOP; back-to-back frames need no idle gap.
REQ-007 Valid DATA frame (stop=1): payload stored at byte slot = data counter (0..7); counter +1.
- Counter saturates at 8.
- A 9th or later DATA frame sets a sticky overflow flag; payload is discarded.
REQ-008 CRC: CRC-4, polynomial x^4+x+1, init 4'h0, computed over the 68-bit stream {B, A, 1'b1, OP}, MSB first.
- Per bit: fb = d ^ c[3]; c = {c[2], c[1], c[0]^fb, fb}.
REQ-009 Valid CTL frame (stop=1) -> out_valid=1 in the cycle after its stop bit is sampled (latency 1 from stop bit).
- out_a, out_b, out_op driven from stored values.
REQ-010 Error flags, evaluated on the CTL frame:
- err_data = (counter != 8) or overflow flag set.
- err_crc = !err_data and received CRC != computed CRC.
- err_op = !err_data and !err_crc and OP not in {000 AND, 001 OR, 100 ADD, 101 SUB}.
- At most one flag set (priority data > crc > op).
REQ-011 After any CTL frame: data counter and overflow flag are cleared, whether or not the packet had errors.
REQ-012 Stop bit = 0 (framing error) on any frame:
- Frame discarded; counter and overflow flag cleared.
- out_valid=1 next cycle with out_err=3'b100 and out_a/out_b/out_op = 0.
REQ-013 out_a, out_b, out_op hold their last values when out_valid=0; out_err is 0 when out_valid=0.
REQ-014 On out_valid with err_data=1, out_a/out_b/out_op = 0.
REQ-015 sin is not sampled by the decoder while rst_n=0.

Reset
REQ-016 rst_n=0 immediately (asynchronously) forces:
- FSM -> IDLE; counter, overflow flag, shift register, byte store cleared.
- out_valid=0, out_a=0, out_b=0, out_op=0, out_err=0.
REQ-017 Reset mid-frame or mid-packet discards all partial data.
- First start bit after rst_n deasserts begins a fresh packet.

Verification
REQ-018 A=0, B=0, OP=AND, CTL payload 8'h0B -> out_valid pulse 1 cycle after CTL stop bit; out_a=0, out_b=0, out_op=000, out_err=000.
REQ-019 A=0, B=0, OP=ADD, CTL payload 8'h47 -> out_op=100, out_err=000; then the same packet with CTL 8'h46 -> out_err=010.
REQ-020 A=32'hFFFF_FFFF, B=32'h0000_00FF, random valid OP, CTL carrying the reference-model CRC, frames back-to-back with no idle gap -> out_a=FFFF_FFFF, out_b=0000_00FF, out_err=000.
REQ-021 Error cases, each with a correct CRC:
- 7 DATA frames + CTL -> out_err=100, outputs 0.
- 9 DATA frames + CTL -> out_err=100, outputs 0.
- 8 DATA frames, OP=010 -> out_err=001.
REQ-022 Framing and reset recovery:
- Stop bit forced 0 on DATA frame 3 -> out_err=100 pulse; the next complete valid packet decodes with out_err=000.
- rst_n pulsed low during DATA frame 5 -> all outputs 0 immediately; no out_valid until a fresh complete packet.
REQ-023 Random: 600 packets of random A/B/OP (including 0/FF corner bytes) -> every out_valid matches the reference-model decode, including err_op for ops 010, 011, 110, 111.

Source files
------------

// File: rtl/mtm_alu_deserializer.sv
// mtm_alu_deserializer: decodes the serial ALU command stream.
// Each packet holds eight DATA frames (operand B then A, MSB byte first) and
// one CTL frame carrying {0, OP, CRC}. The decoded operands, opcode and error
// flags are presented for one cycle after the CTL stop bit. A framing error on
// any frame also produces a one-cycle error pulse.
module mtm_alu_deserializer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sin,
    output logic        out_valid,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [2:0]  out_op,
    output logic [2:0]  out_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TYPE,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q;   // payload bit index within DATA
    logic        is_ctl_q;    // type bit of the frame in flight
    logic [7:0]  shift_q;     // payload, MSB first
    logic [3:0]  data_cnt_q;  // DATA frames accepted, saturates at 8
    logic        overflow_q;  // more than eight DATA frames seen
    logic [63:0] store_q;     // {B, A}; slot 0 lands in bits 63:56

    logic [2:0]  op_rx;
    logic [3:0]  crc_rx;
    logic        err_data, err_crc, err_op;

    // CRC-4, x^4 + x + 1, init 0, over the stream MSB first.
    function automatic logic [3:0] crc4(input logic [67:0] stream);
        logic [3:0] c;
        logic       fb;
        // NOTE: blocking assignments inside a function model the serial
        // recurrence; each iteration sees the previous iteration's result.
        c = 4'h0;
        for (int i = 67; i >= 0; i--) begin
            fb = stream[i] ^ c[3];
            c  = {c[2], c[1], c[0] ^ fb, fb};
        end
        return c;
    endfunction

    assign op_rx  = shift_q[6:4];
    assign crc_rx = shift_q[3:0];

    // Packet checks, only meaningful while a CTL frame sits in STOP.
    always_comb begin
        // NOTE: every output of this block gets a value on every path, so no
        // latch is inferred.
        err_data = (data_cnt_q != 4'd8) || overflow_q;
        err_crc  = 1'b0;
        err_op   = 1'b0;
        if (!err_data) begin
            err_crc = (crc_rx != crc4({store_q, 1'b1, op_rx}));
            if (!err_crc) begin
                err_op = !(op_rx inside {3'b000, 3'b001, 3'b100, 3'b101});
            end
        end
    end

    // Frame state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments for all clocked state so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Frame next-state: start bit, type bit, eight payload bits, stop bit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!sin) state_d = ST_TYPE;
            ST_TYPE: state_d = ST_DATA;
            ST_DATA: if (bit_cnt_q == 3'd7) state_d = ST_STOP;
            ST_STOP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Bit capture: type latch, payload shift register and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= 3'd0;
            is_ctl_q  <= 1'b0;
            shift_q   <= 8'h00;
        end else begin
            bit_cnt_q <= (state_q == ST_DATA) ? bit_cnt_q + 3'd1 : 3'd0;
            if (state_q == ST_TYPE) is_ctl_q <= sin;
            if (state_q == ST_DATA) shift_q  <= {shift_q[6:0], sin};
        end
    end

    // Frame completion: store DATA bytes, decode CTL, report framing errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_cnt_q <= 4'd0;
            overflow_q <= 1'b0;
            // NOTE: the byte store is reset, so a packet cut short by reset
            // can never leak stale operands.
            store_q    <= 64'h0;
            out_valid  <= 1'b0;
            out_a      <= 32'h0;
            out_b      <= 32'h0;
            out_op     <= 3'b000;
            out_err    <= 3'b000;
        end else begin
            out_valid <= 1'b0;
            out_err   <= 3'b000;
            if (state_q == ST_STOP) begin
                if (!sin) begin
                    // Framing error: drop the frame and the partial packet.
                    data_cnt_q <= 4'd0;
                    overflow_q <= 1'b0;
                    out_valid  <= 1'b1;
                    out_err    <= 3'b100;
                    out_a      <= 32'h0;
                    out_b      <= 32'h0;
                    out_op     <= 3'b000;
                end else if (!is_ctl_q) begin
                    if (data_cnt_q == 4'd8) begin
                        overflow_q <= 1'b1;
                    end else begin
                        store_q[{~data_cnt_q[2:0], 3'b000} +: 8] <= shift_q;
                        data_cnt_q <= data_cnt_q + 4'd1;
                    end
                end else begin
                    data_cnt_q <= 4'd0;
                    overflow_q <= 1'b0;
                    out_valid  <= 1'b1;
                    out_err    <= {err_data, err_crc, err_op};
                    if (err_data) begin
                        out_a  <= 32'h0;
                        out_b  <= 32'h0;
                        out_op <= 3'b000;
                    end else begin
                        out_a  <= store_q[31:0];
                        out_b  <= store_q[63:32];
                        out_op <= op_rx;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Self-checking bench for mtm_alu_deserializer: expected decodes are queued
// when a packet is sent and compared whenever the DUT raises out_valid.
module tb_mtm_alu_deserializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sin = 1'b1;
    logic        out_valid;
    logic [31:0] out_a, out_b;
    logic [2:0]  out_op, out_err;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [2:0]  err;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    mtm_alu_deserializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sin       (sin),
        .out_valid (out_valid),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_op    (out_op),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference CRC as a polynomial shift-and-reduce.
    function automatic logic [3:0] ref_crc(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
        logic [67:0] s;
        logic [3:0]  c;
        s = {b, a, 1'b1, op};
        c = 4'h0;
        for (int i = 67; i >= 0; i--) begin
            c = {c[2:0], 1'b0} ^ ((s[i] ^ c[3]) ? 4'b0011 : 4'b0000);
        end
        return c;
    endfunction

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] op, input int n_data,
                                   input logic [3:0] crc);
        exp_t e;
        e = '{a: a, b: b, op: op, err: 3'b000};
        if (n_data != 8)                  e = '{a: 32'h0, b: 32'h0, op: 3'b000, err: 3'b100};
        else if (crc != ref_crc(a, b, op)) e.err = 3'b010;
        else if (!(op inside {3'b000, 3'b001, 3'b100, 3'b101})) e.err = 3'b001;
        return e;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk) sin = 1'b1;
    endtask

    task automatic send_frame(input logic ctl, input logic [7:0] pl, input logic stp);
        logic [10:0] f;
        f = {1'b0, ctl, pl, stp};
        for (int i = 10; i >= 0; i--) @(negedge clk) sin = f[i];
    endtask

    task automatic send_packet(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                               input int n_data, input logic [3:0] crc, input exp_t e);
        logic [63:0] bytes;
        bytes = {b, a};
        for (int i = 0; i < n_data; i++) begin
            if (i < 8) begin
                send_frame(1'b0, bytes[63:56], 1'b1);
                bytes = bytes << 8;
            end else begin
                send_frame(1'b0, 8'($urandom), 1'b1);
            end
        end
        sb_q.push_back(e);
        send_frame(1'b1, {1'b0, op, crc}, 1'b1);
    endtask

    function automatic logic [7:0] rand_byte();
        case ($urandom_range(0, 3))
            0:       return 8'h00;
            1:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    // Scoreboard monitor, sampled 1 ns after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("out_a", out_a, e.a);
                    check("out_b", out_b, e.b);
                    check("out_op", 32'(out_op), 32'(e.op));
                    check("out_err", 32'(out_err), 32'(e.err));
                end
            end else begin
                check("err_when_idle", 32'(out_err), 32'd0);
            end
        end
    end

    initial begin
        logic [31:0] a, b;
        logic [2:0]  op;
        logic [3:0]  crc;
        logic [7:0]  pl;
        int          n;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_a", out_a, 32'd0);
        check("rst_b", out_b, 32'd0);
        check("rst_op", 32'(out_op), 32'd0);
        check("rst_err", 32'(out_err), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Zero operands, AND, literal CTL 0x0B; check latency of one cycle.
        send_packet(32'h0, 32'h0, 3'b000, 8, 4'hB, '{a: 32'h0, b: 32'h0, op: 3'b000, err: 3'b000});
        @(posedge clk); #1;
        check("lat_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        check("pulse_width", 32'(out_valid), 32'd0);
        idle(1);

        // ADD with good CTL 0x47, then bad CRC 0x46.
        send_packet(32'h0, 32'h0, 3'b100, 8, 4'h7, '{a: 32'h0, b: 32'h0, op: 3'b100, err: 3'b000});
        send_packet(32'h0, 32'h0, 3'b100, 8, 4'h6, '{a: 32'h0, b: 32'h0, op: 3'b100, err: 3'b010});

        // All-ones A, B=0xFF, random valid op, back-to-back.
        case ($urandom_range(0, 3))
            0: op = 3'b000;
            1: op = 3'b001;
            2: op = 3'b100;
            default: op = 3'b101;
        endcase
        send_packet(32'hFFFF_FFFF, 32'h0000_00FF, op, 8, ref_crc(32'hFFFF_FFFF, 32'hFF, op),
                    '{a: 32'hFFFF_FFFF, b: 32'h0000_00FF, op: op, err: 3'b000});

        // Frame count errors and a bad opcode, all with correct CRC.
        a = 32'h1234_5678; b = 32'h9ABC_DEF0;
        send_packet(a, b, 3'b100, 7, ref_crc(a, b, 3'b100), '{a: 32'h0, b: 32'h0, op: 3'b000, err: 3'b100});
        send_packet(a, b, 3'b100, 9, ref_crc(a, b, 3'b100), '{a: 32'h0, b: 32'h0, op: 3'b000, err: 3'b100});
        send_packet(a, b, 3'b010, 8, ref_crc(a, b, 3'b010), '{a: a, b: b, op: 3'b010, err: 3'b001});

        // Framing error on the fourth DATA frame, then a clean packet.
        for (int i = 0; i < 3; i++) send_frame(1'b0, 8'hA5, 1'b1);
        sb_q.push_back('{a: 32'h0, b: 32'h0, op: 3'b000, err: 3'b100});
        send_frame(1'b0, 8'h5A, 1'b0);
        idle(2);
        a = 32'hCAFE_0001; b = 32'h0BAD_F00D;
        send_packet(a, b, 3'b101, 8, ref_crc(a, b, 3'b101), '{a: a, b: b, op: 3'b101, err: 3'b000});
        idle(3);

        // Reset pulse part-way through the sixth DATA frame.
        for (int i = 0; i < 5; i++) send_frame(1'b0, 8'h3C, 1'b1);
        pl = 8'hC3;
        @(negedge clk) sin = 1'b0;
        @(negedge clk) sin = 1'b0;
        for (int i = 7; i >= 5; i--) @(negedge clk) sin = pl[i];
        rst_n = 1'b0;
        sin   = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_a", out_a, 32'd0);
        check("mid_rst_b", out_b, 32'd0);
        check("mid_rst_op", 32'(out_op), 32'd0);
        check("mid_rst_err", 32'(out_err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(20);
        a = 32'h0F0F_00FF; b = 32'hFF00_F0F0;
        send_packet(a, b, 3'b001, 8, ref_crc(a, b, 3'b001), '{a: a, b: b, op: 3'b001, err: 3'b000});

        // Random packets, occasionally with a corrupted CRC.
        for (int p = 0; p < 600; p++) begin
            a  = {rand_byte(), rand_byte(), rand_byte(), rand_byte()};
            b  = {rand_byte(), rand_byte(), rand_byte(), rand_byte()};
            op = 3'($urandom_range(0, 7));
            crc = ref_crc(a, b, op);
            if ($urandom_range(0, 7) == 0) crc = crc ^ 4'($urandom_range(1, 15));
            n = 8;
            send_packet(a, b, op, n, crc, model(a, b, op, n, crc));
            idle($urandom_range(0, 2));
        end

        // Drain: every queued decode must have appeared.
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        idle(3);
        check("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
